nic_wb_arbiter: RTL and testbench
=================================

NIC_WB_ARBITER -- requirements
Module: nic_wb_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 2, number of Wishbone masters sharing the node bus (index 0 = NIC noc2wb master); legal range 2..8.
REQ-002 Parameter N_BITS_MASTER, default clog2(N_MASTERS), width of grant index.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, watchdog limit in cycles; legal range 1..65535.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 cyc_i  input  N_MASTERS  per-master CYC request.
REQ-007 ack_i  input  1  slave ACK on shared bus.
REQ-008 err_i  input  1  slave ERR on shared bus.
REQ-009 rty_i  input  1  slave RTY on shared bus.
REQ-010 gnt_o  output  N_MASTERS  one-hot grant; bit 0 drives NIC gnt_wb_i.
REQ-011 gnt_id_o  output  N_BITS_MASTER  index of current/last owner.
REQ-012 bus_busy_o  output  1  high while any grant is held.
REQ-013 timeout_err_o  output  1  one-cycle pulse on watchdog abort.

Function
REQ-014 FSM states SHALL be IDLE, GRANT, ABORT; all outputs registered.
REQ-015 IDLE: if cyc_i != 0, SHALL select first requester scanning from (last_owner+1) mod N_MASTERS upward with wrap-around, and enter GRANT; gnt_o asserted the following cycle (1-cycle latency).
REQ-016 IDLE with cyc_i == 0: SHALL stay in IDLE, gnt_o = 0, bus_busy_o = 0.
REQ-017 GRANT: gnt_o[owner] = 1, bus_busy_o = 1; grant SHALL be held while cyc_i[owner] = 1 regardless of other requests (no preemption).
REQ-018 GRANT with cyc_i[owner] = 0: SHALL return to IDLE; gnt_o = 0 next cycle; last_owner <= owner.
REQ-019 At least one IDLE cycle (bus turnaround) SHALL separate two grants, including back-to-back requests by the same master.
REQ-020 gnt_o SHALL never have more than one bit set; gnt_id_o SHALL hold the last owner value while in IDLE.
REQ-021 Requests arriving while in GRANT or ABORT SHALL be retained only by cyc_i level; no internal request queue.
REQ-022 With round-robin, a continuously requesting master SHALL be granted within N_MASTERS grant periods.

Reset
REQ-023 On rst = 0 at a clock edge: state = IDLE, gnt_o = 0, gnt_id_o = 0, bus_busy_o = 0, timeout_err_o = 0, last_owner = N_MASTERS-1 (master 0 wins first arbitration), watchdog counter = 0.
REQ-024 Reset asserted mid-GRANT or mid-ABORT SHALL drop gnt_o the next cycle with no timeout pulse.

Configuration
REQ-025 Macro NIC_WB_ARB_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-026 With macro: 16-bit counter cleared on GRANT entry and on any ack_i/err_i/rty_i, incremented each other GRANT cycle; saturates, never wraps.
REQ-027 With macro: counter reaching TIMEOUT_CYCLES SHALL move GRANT -> ABORT; gnt_o = 0 and timeout_err_o = 1 for exactly that first ABORT cycle.
REQ-028 With macro: ABORT holds gnt_o = 0, bus_busy_o = 1 until cyc_i[owner] = 0, then IDLE with last_owner <= owner; simultaneous ack_i and limit-reach SHALL clear the counter (ack wins).
REQ-029 Without macro: no counter, ABORT unreachable, timeout_err_o constant 0; GRANT lasts until owner drops CYC.

Verification
REQ-030 Reset, cyc_i = 2'b11 at cycle 0 -> gnt_o = 2'b01 at cycle 1, gnt_id_o = 0.
REQ-031 Master 0 drops CYC after 4 granted cycles, cyc_i[1] held -> one IDLE cycle gnt_o = 0, then gnt_o = 2'b10.
REQ-032 N_MASTERS = 4, cyc_i = 4'b1111 held, each owner releases after 2 cycles -> grant order 0,1,2,3,0 with one gap cycle each.
REQ-033 Macro on, TIMEOUT_CYCLES = 8, owner 1 holds CYC with no ack -> GRANT 8 cycles, gnt_o drops, timeout_err_o pulses once, IDLE after cyc_i[1] falls.
REQ-034 Macro on, ack_i every 5 cycles, TIMEOUT_CYCLES = 8 -> no abort over 100 cycles.
REQ-035 rst = 0 during GRANT of master 1 -> next cycle gnt_o = 0, timeout_err_o = 0; after release master 0 wins first.

Source files
------------

// File: rtl/nic_wb_arbiter.sv
// Round-robin Wishbone bus arbiter for the NIC node bus with a one-cycle turnaround between grants.
// Define NIC_WB_ARB_TIMEOUT_EN to build in the grant watchdog (GRANT -> ABORT on a silent slave).
module nic_wb_arbiter #(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned N_BITS_MASTER  = $clog2(N_MASTERS),
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_MASTERS-1:0]     cyc_i,
  input  logic                     ack_i,
  input  logic                     err_i,
  input  logic                     rty_i,
  output logic [N_MASTERS-1:0]     gnt_o,
  output logic [N_BITS_MASTER-1:0] gnt_id_o,
  output logic                     bus_busy_o,
  output logic                     timeout_err_o
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

  state_t                   state_q, state_d;
  logic [N_BITS_MASTER-1:0] owner_q, owner_d;
  logic [N_BITS_MASTER-1:0] last_q, last_d;
  logic [N_BITS_MASTER-1:0] pick, cand;
  logic                     found;
  logic                     owner_cyc;
  logic [N_MASTERS-1:0]     gnt_d;
  logic                     busy_d;
  logic                     tmo_d;
  logic                     cnt_hit;

  assign owner_cyc = cyc_i[owner_q];
  assign gnt_id_o  = owner_q;

`ifdef NIC_WB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             resp;

  // Quiet-cycle counter: any slave response restarts the window; saturates at all-ones
  assign resp    = ack_i | err_i | rty_i;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign cnt_hit = !resp && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q != GRANT || resp) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_inc;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ack_i ^ err_i ^ rty_i;
  assign cnt_hit     = 1'b0;
`endif

  // Round-robin pick: first requester after the last owner, wrapping
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N_MASTERS; i++) begin
      cand = N_BITS_MASTER'((32'(last_q) + i) % N_MASTERS);
      if (!found && cyc_i[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = '0;
    busy_d  = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          owner_d = pick;
          gnt_d   = N_MASTERS'(1) << pick;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (cnt_hit) begin
          state_d = ABORT;
          busy_d  = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          gnt_d  = N_MASTERS'(1) << owner_q;
          busy_d = 1'b1;
        end
      end
      ABORT: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= N_BITS_MASTER'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_o         <= '0;
      bus_busy_o    <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      gnt_o         <= gnt_d;
      bus_busy_o    <= busy_d;
      timeout_err_o <= tmo_d;
    end
  end

endmodule

// File: tb/tb_nic_wb_arbiter.sv
// Self-checking bench for nic_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_nic_wb_arbiter;

  localparam int unsigned NM = 4;
  localparam int unsigned NB = 2;
  localparam int unsigned TO = 8;
`ifdef NIC_WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NM-1:0] cyc;
  logic          ack, err, rty;
  logic [NM-1:0] gnt;
  logic [NB-1:0] gnt_id;
  logic          busy;
  logic          tmo;

  nic_wb_arbiter #(
    .N_MASTERS     (NM),
    .N_BITS_MASTER (NB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cyc_i        (cyc),
    .ack_i        (ack),
    .err_i        (err),
    .rty_i        (rty),
    .gnt_o        (gnt),
    .gnt_id_o     (gnt_id),
    .bus_busy_o   (busy),
    .timeout_err_o(tmo)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Transaction-level model: who holds the bus, whether the grant was aborted,
  // and how many granted cycles have passed without a slave response.
  int            m_owner;
  int            m_last;
  bit            m_aborted;
  int            m_quiet;
  logic [NM-1:0] e_gnt;
  logic [NB-1:0] e_id;
  logic          e_busy, e_tmo;

  always @(posedge clk) begin
    if (!rst) begin
      m_owner = -1; m_last = NM - 1; m_aborted = 0; m_quiet = 0;
      e_gnt = '0; e_id = '0; e_busy = 1'b0; e_tmo = 1'b0;
    end else begin
      e_tmo = 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= NM; k++) begin
          int c;
          c = (m_last + k) % NM;
          if (m_owner < 0 && cyc[c]) m_owner = c;
        end
        m_aborted = 0;
        m_quiet   = 0;
        e_gnt  = (m_owner >= 0) ? NM'(1) << m_owner : '0;
        e_busy = (m_owner >= 0);
        if (m_owner >= 0) e_id = NB'(m_owner);
      end else if (!cyc[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        e_gnt   = '0;
        e_busy  = 1'b0;
      end else if (m_aborted) begin
        e_gnt  = '0;
        e_busy = 1'b1;
      end else begin
        if (ack || err || rty) m_quiet = 0;
        else if (m_quiet < 65535) m_quiet++;
        if (TO_EN && !(ack || err || rty) && m_quiet == TO) begin
          m_aborted = 1;
          e_gnt     = '0;
          e_tmo     = 1'b1;
        end
        e_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("gnt_o",         32'(gnt),    32'(e_gnt));
      check("gnt_id_o",      32'(gnt_id), 32'(e_id));
      check("bus_busy_o",    32'(busy),   32'(e_busy));
      check("timeout_err_o", 32'(tmo),    32'(e_tmo));
      check("gnt_onehot",    32'($countones(gnt) <= 1), 32'd1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int tmo_pulses;

  initial begin
    rst = 1'b0; cyc = '0; ack = 1'b0; err = 1'b0; rty = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;
    tick(2);

    // Reset values, then first arbitration goes to master 0
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_id",  32'(gnt_id), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1; cyc = 4'b0011;
    tick(1);
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_id",  32'(gnt_id), 32'd0);
    tick(3);
    cyc = 4'b0010;
    tick(1);
    check("turnaround_gap", 32'(gnt), 32'd0);
    check("idle_holds_id",  32'(gnt_id), 32'd0);
    tick(1);
    check("handover_m1", 32'(gnt), 32'h2);
    tick(2);
    cyc = '0;
    tick(2);

    // Four requesters held, each owner releases after 2 cycles: order 0,1,2,3,0
    rst = 1'b0; tick(1); rst = 1'b1; cyc = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [NM-1:0] exp_g;
      exp_g = NM'(1) << (k % NM);
      tick(1);
      check("rr_grant_a", 32'(gnt), 32'(exp_g));
      tick(1);
      check("rr_grant_b", 32'(gnt), 32'(exp_g));
      cyc = ~exp_g;
      tick(1);
      check("rr_gap", 32'(gnt), 32'd0);
      cyc = 4'b1111;
    end
    cyc = '0;
    tick(2);

    // Silent slave: master 1 alone, no responses
    rst = 1'b0; tick(1); rst = 1'b1; cyc = 4'b0010;
    tick(8);
    check("wd_grant_8th", 32'(gnt), 32'h2);
    tick(1);
    check("wd_gnt_drop", 32'(gnt), TO_EN ? 32'd0 : 32'h2);
    check("wd_pulse",    32'(tmo), TO_EN ? 32'd1 : 32'd0);
    check("wd_busy",     32'(busy), 32'd1);
    tick(1);
    check("wd_pulse_once", 32'(tmo), 32'd0);
    tick(1);
    cyc = '0;
    tick(1);
    check("wd_release_idle", 32'(busy), 32'd0);
    check("wd_release_id",   32'(gnt_id), 32'd1);
    tick(1);

    // Periodic ack every 5 cycles keeps the watchdog quiet
    tmo_pulses = 0;
    cyc = 4'b0001;
    for (int i = 0; i < 100; i++) begin
      ack = (i % 5 == 4);
      tick(1);
      if (tmo) tmo_pulses++;
    end
    ack = 1'b0;
    check("ack_no_abort", 32'(tmo_pulses), 32'd0);
    check("ack_still_granted", 32'(gnt), 32'h1);
    cyc = '0;
    tick(2);

    // Reset during master 1's grant
    cyc = 4'b0010;
    tick(3);
    check("pre_reset_gnt", 32'(gnt), 32'h2);
    rst = 1'b0;
    tick(1);
    check("mid_reset_gnt", 32'(gnt), 32'd0);
    check("mid_reset_tmo", 32'(tmo), 32'd0);
    rst = 1'b1; cyc = 4'b1111;
    tick(1);
    check("post_reset_m0", 32'(gnt), 32'h1);
    cyc = '0;
    tick(2);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < NM; m++)
        if ($urandom_range(5) == 0) cyc[m] = ~cyc[m];
      ack = ($urandom_range(11) == 0);
      err = ($urandom_range(40) == 0);
      rty = ($urandom_range(40) == 0);
      rst = ($urandom_range(300) != 0);
      tick(1);
    end
    rst = 1'b1; cyc = '0; ack = 1'b0; err = 1'b0; rty = 1'b0;
    tick(3);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
